// File: rtl/pipelined_fir_n.sv
// Three-stage pipelined N-tap FIR filter with runtime-writable coefficients.
// Define PIPELINED_FIR_N_SATURATE_EN to clamp the output; otherwise it wraps.
module pipelined_fir_n #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 4,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    input  logic [DATA_W-1:0]         i_x,
    input  logic                      i_coefWr,
    input  logic [$clog2(TAPS)-1:0]   i_coefIdx,
    input  logic [COEF_W-1:0]         i_coefData,
    output logic                      o_valid,
    output logic [OUT_W-1:0]          o_y
);
    localparam int IDX_W  = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + IDX_W;
    // One guard bit above the accumulator so the rounding add cannot overflow.
    localparam int EXT_W  = (ACC_W + 1 > OUT_W + 1) ? ACC_W + 1 : OUT_W + 1;
    localparam logic signed [EXT_W-1:0] RND =
        (SHIFT > 0) ? (EXT_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [EXT_W-1:0] YMAX = EXT_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] YMIN = EXT_W'(-(1 << (OUT_W - 1)));

    logic signed [DATA_W-1:0] hist_q [TAPS-1];
    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic signed [DATA_W-1:0] samp   [TAPS];
    logic signed [PROD_W-1:0] prod_q [TAPS];
    logic signed [PROD_W-1:0] prod_d [TAPS];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [EXT_W-1:0]  rnd_sum, shifted;
    logic signed [OUT_W-1:0]  y_q, y_d;
    logic [2:0]               vld_pipe_q;
    logic                     idx_ok;
    logic                     unused_hi;

    generate
        if (TAPS == (1 << IDX_W)) begin : g_idx_full
            assign idx_ok = 1'b1;
        end else begin : g_idx_part
            assign idx_ok = (i_coefIdx < IDX_W'(TAPS));
        end
    endgenerate

    // Stage 1 operands: newest sample from the port, older ones from history.
    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            samp[k]   = (k == 0) ? $signed(i_x) : hist_q[(k == 0) ? 0 : k - 1];
            prod_d[k] = PROD_W'(samp[k]) * PROD_W'(coef_q[k]);
        end
    end

    always_comb begin
        acc_d = '0;
        for (int k = 0; k < TAPS; k++) begin
            acc_d = acc_d + ACC_W'(prod_q[k]);
        end
    end

    always_comb begin
        rnd_sum = EXT_W'(acc_q) + RND;
        shifted = rnd_sum >>> SHIFT;
`ifdef PIPELINED_FIR_N_SATURATE_EN
        if (shifted > YMAX) begin
            y_d = YMAX[OUT_W-1:0];
        end else if (shifted < YMIN) begin
            y_d = YMIN[OUT_W-1:0];
        end else begin
            y_d = shifted[OUT_W-1:0];
        end
`else
        y_d = shifted[OUT_W-1:0];
`endif
    end

    assign unused_hi = ^{shifted[EXT_W-1:OUT_W], YMAX, YMIN};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < TAPS; k++) begin
                coef_q[k] <= '0;
                prod_q[k] <= '0;
            end
            for (int k = 0; k < TAPS - 1; k++) begin
                hist_q[k] <= '0;
            end
            acc_q      <= '0;
            y_q        <= '0;
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[1:0], i_valid};
            if (i_valid) begin
                prod_q    <= prod_d;
                hist_q[0] <= i_x;
                for (int k = 1; k < TAPS - 1; k++) begin
                    hist_q[k] <= hist_q[k-1];
                end
            end
            if (vld_pipe_q[0]) acc_q <= acc_d;
            if (vld_pipe_q[1]) y_q   <= y_d;
            // Products above already captured the old coefficient this cycle.
            if (i_coefWr && idx_ok) coef_q[i_coefIdx] <= i_coefData;
        end
    end

    assign o_valid = vld_pipe_q[2];
    assign o_y     = y_q;
endmodule

// File: tb/tb_pipelined_fir_n.sv
// Randomized bench for pipelined_fir_n, checked every cycle against an
// arithmetic reference model plus hand-computed pins of that model.
module tb_pipelined_fir_n;
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int TAPS   = 4;
    localparam int OUT_W  = 8;
    localparam int SHIFT  = 0;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_valid = 1'b0;
    logic [DATA_W-1:0] i_x = '0;
    logic              i_coefWr = 1'b0;
    logic [1:0]        i_coefIdx = '0;
    logic [COEF_W-1:0] i_coefData = '0;
    logic              o_valid;
    logic [OUT_W-1:0]  o_y;

    pipelined_fir_n #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W), .SHIFT(SHIFT)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_x(i_x),
        .i_coefWr(i_coefWr), .i_coefIdx(i_coefIdx), .i_coefData(i_coefData),
        .o_valid(o_valid), .o_y(o_y)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { int due; longint y; } exp_t;

    int     n_pass = 0;
    int     n_tot  = 0;
    int     cyc    = 0;
    bit     chk_en = 1'b0;
    exp_t   q[$];
    longint m_c [TAPS];
    longint m_x [TAPS];
    longint last_y = 0;
    longint m_last = 0;

    function automatic void check(string name, longint got, longint want);
        n_tot++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
    endfunction

    function automatic longint sx(longint v, int w);
        longint m;
        m = v & ((longint'(1) << w) - 1);
        if (m >= (longint'(1) << (w - 1))) m -= (longint'(1) << w);
        return m;
    endfunction

    function automatic longint fir_out(longint acc);
        longint s;
        int sh;
        sh = SHIFT;
        if (sh > 0) s = (acc + (longint'(1) << (sh - 1))) >>> sh;
        else        s = acc;
`ifdef PIPELINED_FIR_N_SATURATE_EN
        if (s > (longint'(1) << (OUT_W - 1)) - 1) return (longint'(1) << (OUT_W - 1)) - 1;
        if (s < -(longint'(1) << (OUT_W - 1)))    return -(longint'(1) << (OUT_W - 1));
        return s;
`else
        return sx(s, OUT_W);
`endif
    endfunction

    function automatic void model_clear();
        q.delete();
        for (int k = 0; k < TAPS; k++) begin
            m_c[k] = 0;
            m_x[k] = 0;
        end
        last_y = 0;
    endfunction

    // Applied at each rising edge with the inputs the DUT just sampled.
    function automatic void model_edge();
        longint acc;
        if (i_rst) return;
        if (i_valid) begin
            for (int k = TAPS - 1; k > 0; k--) m_x[k] = m_x[k-1];
            m_x[0] = sx(longint'(i_x), DATA_W);
            acc = 0;
            for (int k = 0; k < TAPS; k++) acc += m_c[k] * m_x[k];
            m_last = fir_out(acc);
            q.push_back('{cyc + 2, m_last});
        end
        if (i_coefWr && int'(i_coefIdx) < TAPS)
            m_c[i_coefIdx] = sx(longint'(i_coefData), COEF_W);
    endfunction

    task automatic tick();
        @(posedge i_clk);
        cyc++;
        model_edge();
        #1;
    endtask

    task automatic drive(int v, int x, int wr, int idx, int d);
        i_valid    = v[0];
        i_x        = DATA_W'(x);
        i_coefWr   = wr[0];
        i_coefIdx  = 2'(idx);
        i_coefData = COEF_W'(d);
        tick();
    endtask

    task automatic idle(int n);
        repeat (n) drive(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        model_clear();
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    task automatic set_coefs(int c0, int c1, int c2, int c3);
        drive(0, 0, 1, 0, c0);
        drive(0, 0, 1, 1, c1);
        drive(0, 0, 1, 2, c2);
        drive(0, 0, 1, 3, c3);
    endtask

    task automatic pin(string name, longint want);
        check(name, m_last, want);
    endtask

    always @(negedge i_clk) begin
        exp_t e;
        if (chk_en) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                check("o_valid", longint'(o_valid), 1);
                check("o_y", sx(longint'(o_y), OUT_W), e.y);
                last_y = e.y;
            end else begin
                check("o_valid_idle", longint'(o_valid), 0);
                check("o_y_hold", sx(longint'(o_y), OUT_W), last_y);
            end
        end
    end

    initial begin
        model_clear();
        tick();
        tick();
        chk_en = 1'b1;
        @(negedge i_clk);
        check("reset_y", longint'(o_y), 0);
        check("reset_valid", longint'(o_valid), 0);

        // Impulse response reproduces the coefficients.
        do_reset();
        set_coefs(1, 2, 3, 4);
        drive(1, 1, 0, 0, 0); pin("imp0", 1);
        drive(1, 0, 0, 0, 0); pin("imp1", 2);
        drive(1, 0, 0, 0, 0); pin("imp2", 3);
        drive(1, 0, 0, 0, 0); pin("imp3", 4);
        idle(4);

        // Full-scale positive accumulation.
        do_reset();
        set_coefs(127, 127, 127, 127);
`ifdef PIPELINED_FIR_N_SATURATE_EN
        drive(1, 127, 0, 0, 0); pin("sat0", 127);
        drive(1, 127, 0, 0, 0); pin("sat1", 127);
        drive(1, 127, 0, 0, 0); pin("sat2", 127);
        drive(1, 127, 0, 0, 0); pin("sat3", 127);
`else
        drive(1, 127, 0, 0, 0); pin("wrap0", 1);
        drive(1, 127, 0, 0, 0); pin("wrap1", 2);
        drive(1, 127, 0, 0, 0); pin("wrap2", 3);
        drive(1, 127, 0, 0, 0); pin("wrap3", 4);
`endif
        idle(4);

        // Most-negative product.
        do_reset();
        set_coefs(127, 0, 0, 0);
        drive(1, -128, 0, 0, 0); pin("neg", -128);
        idle(4);

        // Gapped input: history shifts only on accepted samples.
        do_reset();
        set_coefs(1, 1, 1, 1);
        drive(1, 5, 0, 0, 0); pin("gap0", 5);
        idle(3);
        drive(1, 6, 0, 0, 0); pin("gap1", 11);
        idle(4);

        // Coefficient write in the same cycle as a sample uses the old value.
        do_reset();
        set_coefs(1, 1, 1, 1);
        drive(1, 10, 1, 0, 2); pin("haz0", 10);
        drive(1, 10, 0, 0, 0); pin("haz1", 30);
        idle(4);

        // Reset mid-stream discards in-flight work and coefficients.
        do_reset();
        set_coefs(1, 1, 1, 1);
        drive(1, 9, 0, 0, 0);
        i_rst      = 1'b1;
        i_valid    = 1'b1;
        i_coefWr   = 1'b1;
        i_coefData = 8'd5;
        model_clear();
        @(negedge i_clk);
        check("rst_mid_valid", longint'(o_valid), 0);
        check("rst_mid_y", longint'(o_y), 0);
        tick();
        tick();
        i_rst = 1'b0;
        drive(1, 9, 0, 0, 0); pin("rst_after", 0);
        idle(4);

        // Randomized traffic with occasional resets.
        do_reset();
        repeat (800) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else drive(($urandom_range(0, 99) < 60) ? 1 : 0, int'($urandom_range(0, 255)),
                       ($urandom_range(0, 99) < 20) ? 1 : 0, int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 255)));
        end
        idle(6);
        check("queue_drained", longint'(q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
